// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch (IF)
// port and the data-memory (DM) port of the pipeline. Each access takes
// MEM_LAT memory cycles (1..15). DM has priority over IF because it belongs
// to the older instruction. While any request of the current pipeline cycle
// is still unserved, `stall` freezes the pipeline.
//
// Ports
//   clk, rst                  : rising-edge clock, asynchronous active-low reset
//   if_req/if_addr/if_rdata   : fetch request (level), PC, fetched word
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_rdata         : data request (level), store flag, address,
//                               store data, load data
//   stall                     : freeze PC, IF/ID and later pipeline registers
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata       : memory side; mem_rdata is combinational
//                               from mem_addr
//   stall_cnt                 : stall-cycle counter
//
// Build option
//   MEM_ARB_PERF_EN : when defined, stall_cnt counts clock edges with
//                     stall==1, saturating at all-ones. When undefined,
//                     stall_cnt is tied to 0 and no counter is built.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stall_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t            r_state;
  logic              r_owner_dm;
  logic [3:0]        r_cnt;
  logic              r_if_done;
  logic              r_dm_done;
  logic [DATA_W-1:0] r_if_q;
  logic [DATA_W-1:0] r_dm_q;

  logic w_pend_if;
  logic w_pend_dm;
  logic w_sel_dm;
  logic w_active;
  logic w_complete;
  logic w_complete_if;
  logic w_complete_dm;

  always_comb begin
    w_pend_if = if_req & ~r_if_done;
    w_pend_dm = dm_req & ~r_dm_done;
    if (r_state == ST_IDLE) begin
      // Same-cycle grant; DM first.
      w_sel_dm = w_pend_dm;
      w_active = w_pend_if | w_pend_dm;
    end else begin
      // Owner's request dropping while busy is a flush: the access is abandoned.
      w_sel_dm = r_owner_dm;
      w_active = r_owner_dm ? dm_req : if_req;
    end
    // Nothing reaches the memory or the pipeline while reset is held.
    w_active      = w_active & rst;
    // In IDLE r_cnt is 0, so MEM_LAT==1 completes in the grant cycle.
    w_complete    = w_active & (r_cnt == LAST_CNT);
    w_complete_if = w_complete & ~w_sel_dm;
    w_complete_dm = w_complete & w_sel_dm;

    mem_en    = w_active;
    mem_we    = w_complete_dm & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_active) begin
      mem_addr  = w_sel_dm ? dm_addr : if_addr;
      mem_wdata = w_sel_dm ? dm_wdata : '0;
    end

    stall    = rst & ((w_pend_if & ~w_complete_if) | (w_pend_dm & ~w_complete_dm));
    // Completing data bypasses the capture register so it is usable this cycle.
    if_rdata = w_complete_if ? mem_rdata : r_if_q;
    dm_rdata = w_complete_dm ? mem_rdata : r_dm_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_owner_dm <= 1'b0;
      r_cnt      <= 4'd0;
      r_if_done  <= 1'b0;
      r_dm_done  <= 1'b0;
      r_if_q     <= '0;
      r_dm_q     <= '0;
    end else begin
      if (w_complete) begin
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
      end else if (w_active) begin
        r_state    <= ST_BUSY;
        r_cnt      <= r_cnt + 4'd1;
        r_owner_dm <= w_sel_dm;
      end else begin
        // Idle, or an aborted access: start over with no done flag set.
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
      end

      // When the pipeline advances the next cycle's requests are new, so the
      // done flags clear even if an access completed on this same edge.
      if (!stall) begin
        r_if_done <= 1'b0;
        r_dm_done <= 1'b0;
      end else begin
        if (w_complete_if) r_if_done <= 1'b1;
        if (w_complete_dm) r_dm_done <= 1'b1;
      end

      if (w_complete_if)           r_if_q <= mem_rdata;
      if (w_complete_dm && !dm_we) r_dm_q <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
    end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3, each
// with its own memory model. Each access pushes its expected stall length,
// write strobe timing and read data onto a scoreboard queue; the entry is
// popped and compared when the DUT drops stall.
module tb_mem_port_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst;
  logic [N-1:0] if_req;
  logic [N-1:0] dm_req;
  logic [N-1:0] dm_we;
  logic [N-1:0] stall;
  logic [N-1:0] mem_en;
  logic [N-1:0] mem_we;
  logic [31:0]  if_addr   [N];
  logic [31:0]  dm_addr   [N];
  logic [31:0]  dm_wdata  [N];
  logic [31:0]  if_rdata  [N];
  logic [31:0]  dm_rdata  [N];
  logic [31:0]  mem_addr  [N];
  logic [31:0]  mem_wdata [N];
  logic [31:0]  mem_rdata [N];
  logic [31:0]  stall_cnt [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_inst
      logic [31:0] mem [64];

      mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .MEM_LAT(gi + 1)
      ) u_dut (
        .clk      (clk),
        .rst      (rst[gi]),
        .if_req   (if_req[gi]),
        .if_addr  (if_addr[gi]),
        .if_rdata (if_rdata[gi]),
        .dm_req   (dm_req[gi]),
        .dm_we    (dm_we[gi]),
        .dm_addr  (dm_addr[gi]),
        .dm_wdata (dm_wdata[gi]),
        .dm_rdata (dm_rdata[gi]),
        .stall    (stall[gi]),
        .mem_en   (mem_en[gi]),
        .mem_we   (mem_we[gi]),
        .mem_addr (mem_addr[gi]),
        .mem_wdata(mem_wdata[gi]),
        .mem_rdata(mem_rdata[gi]),
        .stall_cnt(stall_cnt[gi])
      );

      always @(posedge clk) begin
        if (mem_en[gi] && mem_we[gi]) mem[mem_addr[gi][7:2]] <= mem_wdata[gi];
      end
      assign mem_rdata[gi] = mem[mem_addr[gi][7:2]];
    end
  endgenerate

  typedef struct {
    logic        chk_if;
    logic [31:0] if_exp;
    logic        chk_dm;
    logic [31:0] dm_exp;
    int          stall_exp;
    int          we_cnt_exp;
    int          we_cyc_exp;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [N][64];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Called at a falling edge; returns at a falling edge with requests cleared.
  task automatic run_access(input int k, input string tag,
                            input logic ifr, input logic [31:0] ia,
                            input logic dmr, input logic we,
                            input logic [31:0] da, input logic [31:0] dw);
    exp_t e;
    exp_t g;
    int   lat   = k + 1;
    int   n_st  = 0;
    int   n_we  = 0;
    int   we_at = -1;
    int   cyc   = 0;
    logic done  = 1'b0;

    e.chk_if     = ifr;
    // DM goes first, so a fetch of the stored word sees the new data.
    e.if_exp     = (dmr && we && (ia[7:2] == da[7:2])) ? dw : ref_mem[k][ia[7:2]];
    e.chk_dm     = dmr & ~we;
    e.dm_exp     = ref_mem[k][da[7:2]];
    e.stall_exp  = (ifr && dmr) ? 2 * lat - 1 : lat - 1;
    e.we_cnt_exp = (dmr && we) ? 1 : 0;
    e.we_cyc_exp = (dmr && we) ? lat - 1 : -1;
    if (dmr && we) ref_mem[k][da[7:2]] = dw;
    sb.push_back(e);

    if_req[k]   = ifr;
    if_addr[k]  = ia;
    dm_req[k]   = dmr;
    dm_we[k]    = we;
    dm_addr[k]  = da;
    dm_wdata[k] = dw;

    while (!done && cyc < 40) begin
      #1;
      if (mem_we[k]) begin
        n_we++;
        we_at = cyc;
      end
      if (!stall[k]) begin
        done = 1'b1;
      end else begin
        n_st++;
        cyc++;
        @(negedge clk);
      end
    end

    check_val({tag, ".done"}, {31'd0, done}, 32'd1);
    g = sb.pop_front();
    check_val({tag, ".stall_cycles"}, 32'(n_st), 32'(g.stall_exp));
    check_val({tag, ".we_pulses"}, 32'(n_we), 32'(g.we_cnt_exp));
    if (g.we_cnt_exp != 0) check_val({tag, ".we_cycle"}, 32'(we_at), 32'(g.we_cyc_exp));
    if (g.chk_if) check_val({tag, ".if_rdata"}, if_rdata[k], g.if_exp);
    if (g.chk_dm) check_val({tag, ".dm_rdata"}, dm_rdata[k], g.dm_exp);
    $display("[%s] lat=%0d stall_cycles=%0d we_pulses=%0d if_rdata=%h dm_rdata=%h",
             tag, lat, n_st, n_we, if_rdata[k], dm_rdata[k]);

    @(negedge clk);
    if_req[k] = 1'b0;
    dm_req[k] = 1'b0;
    dm_we[k]  = 1'b0;
  endtask

  task automatic reset_pulse(input int k);
    rst[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b1;
  endtask

  logic [31:0] perf_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MEM_ARB_PERF_EN
    perf_exp = 32'd3;
`else
    perf_exp = 32'd0;
`endif
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < 64; a++) ref_mem[k][a] = 32'd0;
      if_addr[k]  = 32'd0;
      dm_addr[k]  = 32'd0;
      dm_wdata[k] = 32'd0;
    end
    rst    = '0;
    if_req = '0;
    dm_req = '0;
    dm_we  = '0;
    repeat (2) @(negedge clk);

    // Requests raised while reset is held must not reach memory or stall.
    if_req = '1;
    dm_req = '1;
    dm_we  = '1;
    for (int k = 0; k < N; k++) begin
      if_addr[k]  = 32'h4;
      dm_addr[k]  = 32'h40;
      dm_wdata[k] = 32'hFFFF_0000;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      check_val($sformatf("rst%0d.stall", k), {31'd0, stall[k]}, 32'd0);
      check_val($sformatf("rst%0d.mem_en", k), {31'd0, mem_en[k]}, 32'd0);
      check_val($sformatf("rst%0d.mem_we", k), {31'd0, mem_we[k]}, 32'd0);
      check_val($sformatf("rst%0d.mem_addr", k), mem_addr[k], 32'd0);
      check_val($sformatf("rst%0d.mem_wdata", k), mem_wdata[k], 32'd0);
      check_val($sformatf("rst%0d.if_rdata", k), if_rdata[k], 32'd0);
      check_val($sformatf("rst%0d.dm_rdata", k), dm_rdata[k], 32'd0);
      check_val($sformatf("rst%0d.stall_cnt", k), stall_cnt[k], 32'd0);
    end
    @(negedge clk);
    if_req = '0;
    dm_req = '0;
    dm_we  = '0;
    rst    = '1;
    @(negedge clk);

    // MEM_LAT = 1
    run_access(0, "l1_store40", 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    run_access(0, "l1_store0",  1'b0, 32'h0, 1'b1, 1'b1, 32'h0,  32'h0A0B_0C0D);
    run_access(0, "l1_fetch",   1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0);
    run_access(0, "l1_both_ld", 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    run_access(0, "l1_bypass",  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0);

    // MEM_LAT = 2
    run_access(1, "l2_store0", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h2001_0005);
    run_access(1, "l2_store4", 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h1111_2222);
    run_access(1, "l2_fetch",  1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_pulse(1);
    run_access(1, "l2_both_st", 1'b1, 32'h4, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    check_val("l2.stall_cnt", stall_cnt[1], perf_exp);
    run_access(1, "l2_load40", 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);

    // MEM_LAT = 3
    run_access(2, "l3_store8", 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h55AA_55AA);
    run_access(2, "l3_fetch8", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);

    // Flush: fetch granted, request dropped in cycle 1.
    if_req[2]  = 1'b1;
    if_addr[2] = 32'hC;
    #1;
    check_val("abort.c0_stall", {31'd0, stall[2]}, 32'd1);
    @(negedge clk);
    if_req[2] = 1'b0;
    #1;
    check_val("abort.c1_stall", {31'd0, stall[2]}, 32'd0);
    check_val("abort.c1_we", {31'd0, mem_we[2]}, 32'd0);
    @(negedge clk);
    #1;
    check_val("abort.c2_mem_en", {31'd0, mem_en[2]}, 32'd0);
    check_val("abort.c2_if_rdata", if_rdata[2], 32'h55AA_55AA);
    $display("[abort] lat=3 fetch of 0xC dropped in cycle 1");
    @(negedge clk);
    run_access(2, "l3_refetch", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in cycle 1 of a store: no write may reach memory.
    dm_req[2]   = 1'b1;
    dm_we[2]    = 1'b1;
    dm_addr[2]  = 32'h8;
    dm_wdata[2] = 32'h1234_5678;
    #1;
    check_val("rststore.c0_mem_en", {31'd0, mem_en[2]}, 32'd1);
    check_val("rststore.c0_we", {31'd0, mem_we[2]}, 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    #1;
    check_val("rststore.stall", {31'd0, stall[2]}, 32'd0);
    check_val("rststore.mem_en", {31'd0, mem_en[2]}, 32'd0);
    check_val("rststore.mem_we", {31'd0, mem_we[2]}, 32'd0);
    check_val("rststore.mem_addr", mem_addr[2], 32'd0);
    check_val("rststore.mem_wdata", mem_wdata[2], 32'd0);
    check_val("rststore.if_rdata", if_rdata[2], 32'd0);
    check_val("rststore.dm_rdata", dm_rdata[2], 32'd0);
    dm_req[2] = 1'b0;
    @(negedge clk);
    #1;
    check_val("rststore.c2_we", {31'd0, mem_we[2]}, 32'd0);
    @(negedge clk);
    rst[2]   = 1'b1;
    dm_we[2] = 1'b0;
    $display("[rststore] lat=3 store to 0x8 interrupted by reset");
    @(negedge clk);
    run_access(2, "l3_load8", 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
